pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_entry.sv | 37 +++
 rtl/pipe_stage_reg.sv | 133 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: FSM state encoding
// and the default payload / counter widths.
package pipe_pkg;

  localparam int DEF_DATA_W = 96;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_CNT_W  = 16;

  // EMPTY: nothing held; BUSY: main entry valid; FULL: main and skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of the stage: valid flag plus control and data payload.
// clr_all wipes everything, load captures a new instruction, clr_ctrl
// invalidates the slot while keeping the data payload for observation.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              clr_all,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  // Slot update: squash beats load, load beats invalidate.
  always_ff @(posedge clk) begin
    if (clr_all) begin
      valid  <= 1'b0;
      q_ctrl <= '0;
      q_data <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      q_ctrl <= d_ctrl;
      q_data <= d_data;
    end else if (clr_ctrl) begin
      valid  <= 1'b0;
      q_ctrl <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a two-entry skid buffer so that
// in_ready is purely registered. Supports flush (bubble insertion), keeps
// control bits at zero while the stage is empty, and counts bubble cycles.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic              clr_all;
  logic              main_load, main_clr_ctrl, main_from_skid;
  logic              skid_load, skid_clr_ctrl;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_d_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_d_data, skid_data;

  assign clr_all     = rst | flush;
  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_from_skid ? skid_data : in_data;

  // The skid slot is occupied exactly in FULL, so its flag is a registered ready.
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;

  // State register; reset and flush both return the stage to EMPTY.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and slot control: decides where each incoming word lands.
  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_clr_ctrl  = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr_ctrl  = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (in_valid) begin
          main_load = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_valid && out_ready) begin
          main_load = 1'b1;
        end else if (in_valid) begin
          skid_load = 1'b1;
          state_nxt = ST_FULL;
        end else if (out_ready) begin
          main_clr_ctrl = 1'b1;
          state_nxt     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clr_ctrl  = 1'b1;
          state_nxt      = ST_BUSY;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  pipe_entry #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_main (
    .clk     (clk),
    .clr_all (clr_all),
    .load    (main_load),
    .clr_ctrl(main_clr_ctrl),
    .d_ctrl  (main_d_ctrl),
    .d_data  (main_d_data),
    .valid   (main_valid),
    .q_ctrl  (out_ctrl),
    .q_data  (out_data)
  );

  pipe_entry #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_skid (
    .clk     (clk),
    .clr_all (clr_all),
    .load    (skid_load),
    .clr_ctrl(skid_clr_ctrl),
    .d_ctrl  (in_ctrl),
    .d_data  (in_data),
    .valid   (skid_valid),
    .q_ctrl  (skid_ctrl),
    .q_data  (skid_data)
  );

  // Saturating count of cycles where downstream was ready but we had nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (out_ready && !main_valid && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against
// a queue-based model of the stage.
module tb_pipe_stage_reg;

  localparam int DW = 96;
  localparam int CW = 8;

  logic          clk;
  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   bubble_cnt;

  logic          in_ready4, out_valid4;
  logic [CW-1:0] out_ctrl4;
  logic [DW-1:0] out_data4;
  logic [3:0]    bubble_cnt4;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] m_shown;
  int            m_cnt16;
  int            m_cnt4;
  int            m_sz;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4), .out_data(out_data4),
    .bubble_cnt(bubble_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic iv, input logic ordy,
                               input logic [CW-1:0] c, input logic [DW-1:0] d);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    out_ready = ordy;
    in_ctrl   = c;
    in_data   = d;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the stage is a FIFO of at most two instructions.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_shown = '0;
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else begin
      if (out_ready && mq.size() == 0) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (flush) begin
        mq.delete();
        m_shown = '0;
      end else begin
        m_sz = mq.size();
        if (out_ready && m_sz > 0) void'(mq.pop_front());
        if (in_valid && m_sz < 2) mq.push_back('{c: in_ctrl, d: in_data});
        if (mq.size() > 0) m_shown = mq[0].d;
      end
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("out_valid", {127'b0, out_valid}, {127'b0, mq.size() > 0});
      checkOutput("in_ready", {127'b0, in_ready}, {127'b0, mq.size() < 2});
      checkOutput("out_ctrl", {120'b0, out_ctrl}, {120'b0, (mq.size() > 0) ? mq[0].c : 8'h00});
      checkOutput("out_data", {32'b0, out_data}, {32'b0, m_shown});
      checkOutput("bubble_cnt", {112'b0, bubble_cnt}, 128'(m_cnt16));
      checkOutput("out_valid4", {127'b0, out_valid4}, {127'b0, mq.size() > 0});
      checkOutput("out_data4", {32'b0, out_data4}, {32'b0, m_shown});
      checkOutput("bubble_cnt4", {124'b0, bubble_cnt4}, 128'(m_cnt4));
    end
  end

  initial begin
    logic [DW-1:0] a, b, c, dd;
    logic [15:0]   saved;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ctrl = '0; in_data = '0;

    // Scenario 1: reset then idle with downstream ready.
    applyStimulus(1, 0, 0, 1, 8'h00, '0);
    chk_en = 1;
    applyStimulus(1, 0, 0, 1, 8'h00, '0);
    checkOutput("rst_out_valid", {127'b0, out_valid}, 128'd0);
    checkOutput("rst_out_ctrl", {120'b0, out_ctrl}, 128'd0);
    checkOutput("rst_out_data", {32'b0, out_data}, 128'd0);
    checkOutput("rst_in_ready", {127'b0, in_ready}, 128'd1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 0, 1, 8'h00, '0);
      checkOutput("idle_bubble", {112'b0, bubble_cnt}, 128'(i));
    end

    // Scenario 2: streaming with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 1, 1, 8'(8'h80 + i), DW'(i));
      checkOutput("stream_data", {32'b0, out_data}, 128'(i));
      checkOutput("stream_ctrl", {120'b0, out_ctrl}, 128'(8'h80 + i));
      checkOutput("stream_ready", {127'b0, in_ready}, 128'd1);
      if (i == 1) saved = bubble_cnt;
    end
    checkOutput("stream_bubble", {112'b0, bubble_cnt}, {112'b0, saved});
    applyStimulus(0, 0, 0, 1, 8'h00, '0);

    // Scenario 3: stall into FULL, then drain in order.
    a = 96'hA; b = 96'hB; c = 96'hC;
    applyStimulus(0, 0, 1, 0, 8'h1A, a);
    applyStimulus(0, 0, 1, 0, 8'h1B, b);
    checkOutput("full_in_ready", {127'b0, in_ready}, 128'd0);
    checkOutput("full_data_a", {32'b0, out_data}, {32'b0, a});
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 8'h1C, c);
    checkOutput("hold_data_a", {32'b0, out_data}, {32'b0, a});
    applyStimulus(0, 0, 1, 1, 8'h1C, c);
    checkOutput("drain_b", {32'b0, out_data}, {32'b0, b});
    checkOutput("drain_b_ctrl", {120'b0, out_ctrl}, 128'h1B);
    applyStimulus(0, 0, 1, 1, 8'h1C, c);
    checkOutput("drain_c", {32'b0, out_data}, {32'b0, c});
    applyStimulus(0, 0, 0, 1, 8'h00, '0);
    checkOutput("drain_empty", {127'b0, out_valid}, 128'd0);
    checkOutput("drain_ctrl0", {120'b0, out_ctrl}, 128'd0);
    checkOutput("drain_held", {32'b0, out_data}, {32'b0, c});

    // Scenario 4: flush a FULL stage while presenting D.
    dd = 96'hD;
    applyStimulus(0, 0, 1, 0, 8'h2A, a);
    applyStimulus(0, 0, 1, 0, 8'h2B, b);
    applyStimulus(0, 1, 1, 1, 8'h2D, dd);
    checkOutput("flush_valid", {127'b0, out_valid}, 128'd0);
    checkOutput("flush_ctrl", {120'b0, out_ctrl}, 128'd0);
    checkOutput("flush_data", {32'b0, out_data}, 128'd0);
    checkOutput("flush_ready", {127'b0, in_ready}, 128'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 8'h00, '0);
      checkOutput("flush_no_leak", {127'b0, out_valid}, 128'd0);
    end

    // Scenario 5: bubble counter saturation on the 4-bit instance.
    applyStimulus(1, 0, 0, 1, 8'h00, '0);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0, 0, 0, 1, 8'h00, '0);
      if (i == 14) checkOutput("sat_14", {124'b0, bubble_cnt4}, 128'd14);
      if (i == 15) checkOutput("sat_15", {124'b0, bubble_cnt4}, 128'd15);
    end
    checkOutput("sat_hold", {124'b0, bubble_cnt4}, 128'd15);
    checkOutput("cnt16_20", {112'b0, bubble_cnt}, 128'd20);

    // Scenario 6: reset and flush together from FULL.
    applyStimulus(0, 0, 1, 0, 8'h3A, a);
    applyStimulus(0, 0, 1, 0, 8'h3B, b);
    applyStimulus(1, 1, 1, 1, 8'h3D, dd);
    checkOutput("rf_valid", {127'b0, out_valid}, 128'd0);
    checkOutput("rf_ctrl", {120'b0, out_ctrl}, 128'd0);
    checkOutput("rf_data", {32'b0, out_data}, 128'd0);
    checkOutput("rf_ready", {127'b0, in_ready}, 128'd1);
    checkOutput("rf_bubble", {112'b0, bubble_cnt}, 128'd0);
    checkOutput("rf_bubble4", {124'b0, bubble_cnt4}, 128'd0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(199) == 0, $urandom_range(49) == 0,
                    $urandom_range(99) < 60, $urandom_range(99) < 65,
                    8'($urandom), {$urandom, $urandom, $urandom});
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
